// File: rtl/spi_slave_9952.sv
// spi_slave_9952: AD9952-style serial register responder.
// Decodes instruction/data bytes from an SPI master into a buffered register
// file, copies buffers to the active outputs on io_update, and answers reads
// on miso. All serial inputs are oversampled by clk through synchronizers.
module spi_slave_9952 #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        n_cs,
    input  logic        mosi,
    input  logic        io_update,
    output logic        miso,
    output logic        miso_oe,
    output logic [31:0] cfr1,
    output logic [23:0] cfr2,
    output logic [15:0] asf,
    output logic [7:0]  arr,
    output logic [31:0] ftw0,
    output logic [15:0] pow0,
    output logic        wr_done,
    output logic        upd_done
);

    typedef enum logic [1:0] {
        ST_INSTR   = 2'd0,
        ST_WR_DATA = 2'd1,
        ST_RD_DATA = 2'd2
    } state_t;

    // Register length in bytes; unmapped addresses behave as 1-byte dummies.
    function automatic logic [2:0] reg_len(input logic [4:0] addr);
        case (addr)
            5'h00:   reg_len = 3'd4;
            5'h01:   reg_len = 3'd3;
            5'h02:   reg_len = 3'd2;
            5'h03:   reg_len = 3'd1;
            5'h04:   reg_len = 3'd4;
            5'h05:   reg_len = 3'd2;
            default: reg_len = 3'd1;
        endcase
    endfunction

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] n_cs_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic [SYNC_STAGES-1:0] upd_sync_r;
    logic                   sclk_d_r;
    logic                   upd_d_r;

    logic sclk_s, n_cs_s, mosi_s, upd_s;
    logic sclk_rise_s, sclk_fall_s, upd_rise_s;

    state_t      state_r, state_n;
    logic [5:0]  bit_cnt_r, bit_cnt_n;
    logic [2:0]  byte_cnt_r, byte_cnt_n;
    logic [4:0]  addr_r, addr_n;
    logic [31:0] shift_r, shift_n;
    logic [31:0] out_shift_r, out_shift_n;
    logic        miso_r, miso_n;
    logic        miso_oe_r, miso_oe_n;
    logic        wr_done_r, wr_done_n;
    logic        upd_done_r;
    logic        commit_s;
    logic        last_bit_s;
    logic [7:0]  instr_byte_s;
    logic [31:0] rd_val_s;

    logic [31:0] buf_cfr1_r, buf_cfr1_n, act_cfr1_r;
    logic [23:0] buf_cfr2_r, buf_cfr2_n, act_cfr2_r;
    logic [15:0] buf_asf_r,  buf_asf_n,  act_asf_r;
    logic [7:0]  buf_arr_r,  buf_arr_n,  act_arr_r;
    logic [31:0] buf_ftw0_r, buf_ftw0_n, act_ftw0_r;
    logic [15:0] buf_pow0_r, buf_pow0_n, act_pow0_r;

    // Synchronizer chains plus one-clk-delayed copies for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            n_cs_sync_r <= {SYNC_STAGES{1'b1}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            upd_sync_r  <= {SYNC_STAGES{1'b0}};
            sclk_d_r    <= 1'b0;
            upd_d_r     <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
            n_cs_sync_r <= {n_cs_sync_r[SYNC_STAGES-2:0], n_cs};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
            upd_sync_r  <= {upd_sync_r[SYNC_STAGES-2:0], io_update};
            sclk_d_r    <= sclk_sync_r[SYNC_STAGES-1];
            upd_d_r     <= upd_sync_r[SYNC_STAGES-1];
        end
    end

    assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
    assign n_cs_s      = n_cs_sync_r[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
    assign upd_s       = upd_sync_r[SYNC_STAGES-1];
    // sclk edges only count while the chip is selected.
    assign sclk_rise_s = sclk_s & ~sclk_d_r & ~n_cs_s;
    assign sclk_fall_s = ~sclk_s & sclk_d_r & ~n_cs_s;
    assign upd_rise_s  = upd_s & ~upd_d_r;

    assign instr_byte_s = {shift_r[6:0], mosi_s};
    assign last_bit_s   = (bit_cnt_r == ({byte_cnt_r, 3'b000} - 6'd1));

    // Left-aligned buffer value for the register addressed by the incoming instruction.
    always_comb begin
        case (instr_byte_s[4:0])
            5'h00:   rd_val_s = buf_cfr1_r;
            5'h01:   rd_val_s = {buf_cfr2_r, 8'h00};
            5'h02:   rd_val_s = {buf_asf_r, 16'h0000};
            5'h03:   rd_val_s = {buf_arr_r, 24'h000000};
            5'h04:   rd_val_s = buf_ftw0_r;
            5'h05:   rd_val_s = {buf_pow0_r, 16'h0000};
            default: rd_val_s = 32'h0000_0000;
        endcase
    end

    // Serial protocol FSM: next state, counters, shift registers and miso.
    always_comb begin
        state_n     = state_r;
        bit_cnt_n   = bit_cnt_r;
        byte_cnt_n  = byte_cnt_r;
        addr_n      = addr_r;
        shift_n     = shift_r;
        out_shift_n = out_shift_r;
        miso_n      = miso_r;
        miso_oe_n   = miso_oe_r;
        wr_done_n   = 1'b0;
        commit_s    = 1'b0;
        if (n_cs_s) begin
            // Deselected: abandon any partial instruction or data.
            state_n    = ST_INSTR;
            bit_cnt_n  = 6'd0;
            byte_cnt_n = 3'd0;
            miso_n     = 1'b0;
            miso_oe_n  = 1'b0;
        end else begin
            case (state_r)
                ST_INSTR: begin
                    if (sclk_rise_s) begin
                        shift_n = {shift_r[30:0], mosi_s};
                        if (bit_cnt_r == 6'd7) begin
                            addr_n     = instr_byte_s[4:0];
                            byte_cnt_n = reg_len(instr_byte_s[4:0]);
                            bit_cnt_n  = 6'd0;
                            if (instr_byte_s[7]) begin
                                state_n     = ST_RD_DATA;
                                out_shift_n = rd_val_s;
                            end else begin
                                state_n = ST_WR_DATA;
                            end
                        end else begin
                            bit_cnt_n = bit_cnt_r + 6'd1;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt_r;
                    end
                end
                ST_WR_DATA: begin
                    if (sclk_rise_s) begin
                        shift_n = {shift_r[30:0], mosi_s};
                        if (last_bit_s) begin
                            commit_s  = 1'b1;
                            wr_done_n = (addr_r < 5'd6);
                            state_n   = ST_INSTR;
                            bit_cnt_n = 6'd0;
                        end else begin
                            bit_cnt_n = bit_cnt_r + 6'd1;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt_r;
                    end
                end
                ST_RD_DATA: begin
                    if (sclk_fall_s) begin
                        miso_n      = out_shift_r[31];
                        out_shift_n = {out_shift_r[30:0], 1'b0};
                        miso_oe_n   = 1'b1;
                    end else if (sclk_rise_s) begin
                        if (last_bit_s) begin
                            state_n   = ST_INSTR;
                            bit_cnt_n = 6'd0;
                            miso_n    = 1'b0;
                            miso_oe_n = 1'b0;
                        end else begin
                            bit_cnt_n = bit_cnt_r + 6'd1;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt_r;
                    end
                end
                default: begin
                    state_n   = ST_INSTR;
                    bit_cnt_n = 6'd0;
                end
            endcase
        end
    end

    // Buffer register file update on a committed write; dummy addresses drop the data.
    always_comb begin
        buf_cfr1_n = buf_cfr1_r;
        buf_cfr2_n = buf_cfr2_r;
        buf_asf_n  = buf_asf_r;
        buf_arr_n  = buf_arr_r;
        buf_ftw0_n = buf_ftw0_r;
        buf_pow0_n = buf_pow0_r;
        if (commit_s) begin
            case (addr_r)
                5'h00:   buf_cfr1_n = shift_n;
                5'h01:   buf_cfr2_n = shift_n[23:0];
                5'h02:   buf_asf_n  = shift_n[15:0];
                5'h03:   buf_arr_n  = shift_n[7:0];
                5'h04:   buf_ftw0_n = shift_n;
                5'h05:   buf_pow0_n = shift_n[15:0];
                default: buf_cfr1_n = buf_cfr1_r;
            endcase
        end else begin
            buf_cfr1_n = buf_cfr1_r;
        end
    end

    // FSM state, counters, shifters and registered serial outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_INSTR;
            bit_cnt_r   <= 6'd0;
            byte_cnt_r  <= 3'd0;
            addr_r      <= 5'd0;
            shift_r     <= 32'd0;
            out_shift_r <= 32'd0;
            miso_r      <= 1'b0;
            miso_oe_r   <= 1'b0;
            wr_done_r   <= 1'b0;
        end else begin
            state_r     <= state_n;
            bit_cnt_r   <= bit_cnt_n;
            byte_cnt_r  <= byte_cnt_n;
            addr_r      <= addr_n;
            shift_r     <= shift_n;
            out_shift_r <= out_shift_n;
            miso_r      <= miso_n;
            miso_oe_r   <= miso_oe_n;
            wr_done_r   <= wr_done_n;
        end
    end

    // Buffer and active registers; a same-clk commit is visible to the transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_cfr1_r <= 32'd0;
            buf_cfr2_r <= 24'd0;
            buf_asf_r  <= 16'd0;
            buf_arr_r  <= 8'd0;
            buf_ftw0_r <= 32'd0;
            buf_pow0_r <= 16'd0;
            act_cfr1_r <= 32'd0;
            act_cfr2_r <= 24'd0;
            act_asf_r  <= 16'd0;
            act_arr_r  <= 8'd0;
            act_ftw0_r <= 32'd0;
            act_pow0_r <= 16'd0;
            upd_done_r <= 1'b0;
        end else begin
            buf_cfr1_r <= buf_cfr1_n;
            buf_cfr2_r <= buf_cfr2_n;
            buf_asf_r  <= buf_asf_n;
            buf_arr_r  <= buf_arr_n;
            buf_ftw0_r <= buf_ftw0_n;
            buf_pow0_r <= buf_pow0_n;
            upd_done_r <= upd_rise_s;
            if (upd_rise_s) begin
                act_cfr1_r <= buf_cfr1_n;
                act_cfr2_r <= buf_cfr2_n;
                act_asf_r  <= buf_asf_n;
                act_arr_r  <= buf_arr_n;
                act_ftw0_r <= buf_ftw0_n;
                act_pow0_r <= buf_pow0_n;
            end else begin
                act_cfr1_r <= act_cfr1_r;
            end
        end
    end

    assign miso     = miso_r;
    assign miso_oe  = miso_oe_r;
    assign wr_done  = wr_done_r;
    assign upd_done = upd_done_r;
    assign cfr1     = act_cfr1_r;
    assign cfr2     = act_cfr2_r;
    assign asf      = act_asf_r;
    assign arr      = act_arr_r;
    assign ftw0     = act_ftw0_r;
    assign pow0     = act_pow0_r;

endmodule
